fetch_unit: RTL and testbench

//  Fetch stage directly upstream of instruction_memory. Owns the fetch PC, drives it
//  as the combinational read address, and captures {pc, instruction} pairs into a small

---
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, reads instruction memory combinationally and queues
// {pc, instr} pairs in a small FIFO. Optional misaligned-redirect trap: FETCH_MISALIGN_CHK_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        misalign_err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   localparam logic [1:0] OCC_EMPTY   = 2'd0;
   localparam logic [1:0] OCC_PARTIAL = 2'd1;
   localparam logic [1:0] OCC_FULL    = 2'd2;

   logic [31:0]      fetch_pc;
   logic [CNT_W-1:0] count;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [31:0]      pc_q    [DEPTH];
   logic [31:0]      instr_q [DEPTH];
   logic [1:0]       occ;
   logic             halted;
   logic             misaligned;
   logic             push;
   logic             pop;
   logic [31:0]      redirect_target;

   assign redirect_target = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHK_EN
   assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

   // Once a misaligned target is seen the fetch stream stays frozen until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halted       <= 1'b0;
         misalign_err <= 1'b0;
      end else if (misaligned) begin
         halted       <= 1'b1;
         misalign_err <= 1'b1;
      end
   end
`else
   logic unused_lsbs;

   assign unused_lsbs  = ^redirect_pc[1:0];
   assign misaligned   = 1'b0;
   assign halted       = 1'b0;
   assign misalign_err = 1'b0;
`endif

   always_comb begin
      occ = OCC_PARTIAL;
      if (count == '0) begin
         occ = OCC_EMPTY;
      end else if (count == DEPTH_C) begin
         occ = OCC_FULL;
      end
   end

   // Fullness is judged before any same-cycle pop, so FULL+pop leaves a bubble slot.
   assign push = !redirect_valid && (occ != OCC_FULL) && !halted;
   assign pop  = out_valid && out_ready && !redirect_valid;

   assign imem_addr = fetch_pc;
   assign out_valid = (occ != OCC_EMPTY);
   assign out_instr = instr_q[rd_ptr];
   assign out_pc    = pc_q[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else if (redirect_valid) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         if (!misaligned) begin
            fetch_pc <= redirect_target;
         end
      end else begin
         if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
            wr_ptr   <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
         end
      end else if (push) begin
         pc_q[wr_ptr]    <= fetch_pc;
         instr_q[wr_ptr] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected {pc, instr} pairs are queued by the stimulus
// and checked by a monitor on every accepted FIFO head.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        misalign_err;

   int n_checks = 0;
   int n_pass   = 0;
   logic [63:0] exp_q [$];

   localparam logic [31:0] I0 = 32'h00208233;
   localparam logic [31:0] I1 = 32'h003203B3;
   localparam logic [31:0] I2 = 32'h00C585B3;
   localparam logic [31:0] I3 = 32'h0002A303;
   localparam logic [31:0] I4 = 32'h006303B3;

   fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .misalign_err   (misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a[31:2])
         30'd0:   return I0;
         30'd1:   return I1;
         30'd2:   return I2;
         30'd3:   return I3;
         30'd4:   return I4;
         default: return a ^ 32'hFFFF_0000;
      endcase
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic expect_pair(input logic [31:0] pc);
      exp_q.push_back({pc, mem_word(pc)});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_ready(input int n);
      out_ready = 1'b1;
      repeat (n) step();
      out_ready = 1'b0;
   endtask

   // Every accepted head must match the next queued expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready && !redirect_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pop", {out_pc, out_instr}, 64'hx);
         end else begin
            chk("pop_pc_instr", {out_pc, out_instr}, exp_q.pop_front());
         end
      end
   end

   initial begin
      rst_n          = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_pc", 64'(out_pc), 64'd0);
      chk("rst_out_instr", 64'(out_instr), 64'd0);
      chk("rst_imem_addr", 64'(imem_addr), 64'd0);
      chk("rst_misalign_err", 64'(misalign_err), 64'd0);
      step();

      // Stream start after reset release
      rst_n = 1'b1;
      expect_pair(32'h0);
      expect_pair(32'h4);
      expect_pair(32'h8);
      run_ready(4);
      chk("t1_drain", 64'(exp_q.size()), 64'd0);

      // Back-pressure: restart at 0 with consumer stalled
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      step();
      redirect_valid = 1'b0;
      chk("t2_flush_valid", 64'(out_valid), 64'd0);
      chk("t2_flush_addr", 64'(imem_addr), 64'd0);
      repeat (5) step();
      chk("t2_full_valid", 64'(out_valid), 64'd1);
      chk("t2_full_addr", 64'(imem_addr), 64'h8);
      chk("t2_full_pc", 64'(out_pc), 64'h0);
      chk("t2_full_instr", 64'(out_instr), 64'(I0));
      expect_pair(32'h0);
      expect_pair(32'h4);
      expect_pair(32'h8);
      expect_pair(32'hC);
      run_ready(4);
      chk("t2_drain", 64'(exp_q.size()), 64'd0);

      // Redirect while full with a concurrent pop request
      step();
      chk("t3_full_addr", 64'(imem_addr), 64'h18);
      chk("t3_head_pc", 64'(out_pc), 64'h10);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h10;
      out_ready      = 1'b1;
      step();
      redirect_valid = 1'b0;
      chk("t3_redir_valid", 64'(out_valid), 64'd0);
      chk("t3_redir_addr", 64'(imem_addr), 64'h10);
      expect_pair(32'h10);
      repeat (2) step();
      out_ready = 1'b0;
      chk("t3_drain", 64'(exp_q.size()), 64'd0);

      // PC wrap at top of address space
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      chk("t5_addr_top", 64'(imem_addr), 64'hFFFF_FFFC);
      step();
      chk("t5_addr_wrap", 64'(imem_addr), 64'h0);
      chk("t5_head_pc", 64'(out_pc), 64'hFFFF_FFFC);
      chk("t5_no_err", 64'(misalign_err), 64'd0);
      expect_pair(32'hFFFF_FFFC);
      expect_pair(32'h0);
      run_ready(2);
      chk("t5_drain", 64'(exp_q.size()), 64'd0);

      // Asynchronous reset mid-stream
      chk("t4_pre_valid", 64'(out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t4_async_valid", 64'(out_valid), 64'd0);
      chk("t4_async_addr", 64'(imem_addr), 64'h0);
      chk("t4_async_pc", 64'(out_pc), 64'h0);
      step();
      rst_n = 1'b1;
      expect_pair(32'h0);
      expect_pair(32'h4);
      expect_pair(32'h8);
      run_ready(4);
      chk("t4_drain", 64'(exp_q.size()), 64'd0);

      // Misaligned redirect
      redirect_valid = 1'b1;
      redirect_pc    = 32'h12;
      step();
      redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      chk("t6_err_set", 64'(misalign_err), 64'd1);
      chk("t6_pc_held", 64'(imem_addr), 64'h10);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("t6_halt_valid", 64'(out_valid), 64'd0);
      end
      out_ready      = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      step();
      redirect_valid = 1'b0;
      step();
      chk("t6_err_sticky", 64'(misalign_err), 64'd1);
      chk("t6_still_halted", 64'(out_valid), 64'd0);
`else
      chk("t6_no_err", 64'(misalign_err), 64'd0);
      chk("t6_aligned_addr", 64'(imem_addr), 64'h10);
      expect_pair(32'h10);
      run_ready(2);
      chk("t6_drain", 64'(exp_q.size()), 64'd0);
      chk("t6_err_after", 64'(misalign_err), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
